// File: rtl/modn_count_monitor.sv
// modn_count_monitor
// Watches the count bus of a mod-N up/down counter, recovers its direction,
// flags illegal steps, out-of-range values and counter resets, and keeps
// a saturating error count and a free-running wrap count.
module modn_count_monitor #(
  parameter int N  = 10,
  parameter int W  = 4,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_en,
  input  logic [W-1:0]  count_in,
  input  logic          clear_err,
  output logic          dir,
  output logic          locked,
  output logic          wrap_pulse,
  output logic          dir_change,
  output logic          reset_seen,
  output logic          step_err,
  output logic          range_err,
  output logic [EW-1:0] err_count,
  output logic [15:0]   wrap_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [W-1:0]  LAST    = W'(N - 1);
  localparam logic [EW-1:0] ERR_MAX = '1;

  state_t        state, next_state;
  logic [W-1:0]  prev, next_prev;
  logic          next_dir;

  logic [W-1:0]  up_prev, dn_prev, fwd_val, rev_val;
  logic          in_range, is_up, is_dn, is_hold, is_fwd, is_rev;

  logic          wrap_d, dchg_d, rseen_d, serr_d, rerr_d;

  // Classify the current sample relative to the last legal value and direction
  always_comb begin
    in_range = (count_in <= LAST);
    up_prev  = (prev == LAST) ? '0 : prev + 1'b1;
    dn_prev  = (prev == '0) ? LAST : prev - 1'b1;
    fwd_val  = dir ? up_prev : dn_prev;
    rev_val  = dir ? dn_prev : up_prev;
    is_up    = (count_in == up_prev);
    is_dn    = (count_in == dn_prev);
    is_hold  = (count_in == prev);
    is_fwd   = (count_in == fwd_val);
    // For N = 2 forward and reverse coincide, so a match is always a continue
    is_rev   = !is_fwd && (count_in == rev_val);
  end

  // State, last value and direction registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      prev  <= '0;
      dir   <= 1'b1;
    end else begin
      state <= next_state;
      prev  <= next_prev;
      dir   <= next_dir;
    end
  end

  // Next state, last value and direction; out-of-range samples never update prev
  always_comb begin
    next_state = state;
    next_prev  = prev;
    next_dir   = dir;
    if (sample_en) begin
      if (!in_range) begin
        if (state == TRACK) next_state = ACQ;
      end else begin
        next_prev = count_in;
        case (state)
          IDLE: next_state = ACQ;
          ACQ: begin
            if (is_up) begin
              next_state = TRACK;
              next_dir   = 1'b1;
            end else if (is_dn) begin
              next_state = TRACK;
              next_dir   = 1'b0;
            end
          end
          TRACK: begin
            if (is_fwd) begin
              next_state = TRACK;
            end else if (is_rev) begin
              next_dir = !dir;
            end else if (count_in == '0) begin
              next_state = ACQ;
            end else if (!is_hold) begin
              next_state = ACQ;
            end
          end
          default: next_state = IDLE;
        endcase
      end
    end
  end

  // Event decode for this sample; a wrap is an up step out of N-1 or a down step out of 0
  always_comb begin
    wrap_d  = 1'b0;
    dchg_d  = 1'b0;
    rseen_d = 1'b0;
    serr_d  = 1'b0;
    rerr_d  = 1'b0;
    if (sample_en) begin
      if (!in_range) begin
        rerr_d = 1'b1;
      end else begin
        case (state)
          ACQ: begin
            if (!(is_up || is_dn || is_hold)) serr_d = 1'b1;
          end
          TRACK: begin
            if (is_fwd) begin
              wrap_d = dir ? (prev == LAST) : (prev == '0);
            end else if (is_rev) begin
              dchg_d = 1'b1;
              wrap_d = dir ? (prev == '0) : (prev == LAST);
            end else if (count_in == '0) begin
              rseen_d = 1'b1;
            end else if (!is_hold) begin
              serr_d = 1'b1;
            end
          end
          default: begin
            wrap_d = 1'b0;
          end
        endcase
      end
    end
  end

  // Registered flags so every output lines up one cycle after its sampling edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      dir_change <= 1'b0;
      reset_seen <= 1'b0;
      step_err   <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      locked     <= (next_state == TRACK);
      wrap_pulse <= wrap_d;
      dir_change <= dchg_d;
      reset_seen <= rseen_d;
      step_err   <= serr_d;
      range_err  <= rerr_d;
    end
  end

  // Event counters; a clear in the same cycle as an event leaves the counter at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count  <= '0;
      wrap_count <= '0;
    end else if (clear_err) begin
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      if ((serr_d || rerr_d) && (err_count != ERR_MAX)) err_count <= err_count + 1'b1;
      if (wrap_d) wrap_count <= wrap_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_modn_count_monitor.sv
// tb_modn_count_monitor
// Directed vectors for the mod-10 count monitor with hand-computed flags.
// Flag vector order: {locked, dir, wrap_pulse, dir_change, reset_seen, step_err, range_err}.
module tb_modn_count_monitor;

  localparam int N  = 10;
  localparam int W  = 4;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_en;
  logic [W-1:0]  count_in;
  logic          clear_err;
  logic          dir, locked, wrap_pulse, dir_change, reset_seen, step_err, range_err;
  logic [EW-1:0] err_count;
  logic [15:0]   wrap_count;
  logic [6:0]    flags;

  int total = 0;
  int bad   = 0;

  modn_count_monitor #(.N(N), .W(W), .EW(EW)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .count_in   (count_in),
    .clear_err  (clear_err),
    .dir        (dir),
    .locked     (locked),
    .wrap_pulse (wrap_pulse),
    .dir_change (dir_change),
    .reset_seen (reset_seen),
    .step_err   (step_err),
    .range_err  (range_err),
    .err_count  (err_count),
    .wrap_count (wrap_count)
  );

  assign flags = {locked, dir, wrap_pulse, dir_change, reset_seen, step_err, range_err};

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input int val, input logic clr);
    @(negedge clk);
    sample_en = en;
    count_in  = W'(val);
    clear_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input int val, input logic [6:0] exp);
    applyStimulus(1'b1, val, 1'b0);
    checkOutput(tag, 32'(flags), 32'(exp));
  endtask

  task automatic doReset();
    @(negedge clk);
    reset     = 1'b0;
    sample_en = 1'b0;
    clear_err = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Directed scenario sequence
  initial begin
    reset     = 1'b0;
    sample_en = 1'b0;
    count_in  = '0;
    clear_err = 1'b0;
    #12;
    checkOutput("reset_flags", 32'(flags), 32'(7'b0100000));
    checkOutput("reset_err", 32'(err_count), 32'd0);
    checkOutput("reset_wrap", 32'(wrap_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Up run 0..9,0,1
    for (int v = 0; v < N; v++)
      step($sformatf("up_%0d", v), v, (v == 0) ? 7'b0100000 : 7'b1100000);
    step("up_wrap", 0, 7'b1110000);
    step("up_after_wrap", 1, 7'b1100000);
    checkOutput("up_wrap_count", 32'(wrap_count), 32'd1);
    checkOutput("up_err_count", 32'(err_count), 32'd0);

    // Down run 5,4,3,2,1,0,9,8
    doReset();
    step("dn_5", 5, 7'b0100000);
    step("dn_4", 4, 7'b1000000);
    step("dn_3", 3, 7'b1000000);
    step("dn_2", 2, 7'b1000000);
    step("dn_1", 1, 7'b1000000);
    step("dn_0", 0, 7'b1000000);
    step("dn_wrap", 9, 7'b1010000);
    step("dn_8", 8, 7'b1000000);
    checkOutput("dn_wrap_count", 32'(wrap_count), 32'd1);
    checkOutput("dn_err_count", 32'(err_count), 32'd0);

    // Reversal 3,4,5,4,3
    doReset();
    step("rev_3", 3, 7'b0100000);
    step("rev_4", 4, 7'b1100000);
    step("rev_5", 5, 7'b1100000);
    step("rev_turn", 4, 7'b1001000);
    step("rev_3b", 3, 7'b1000000);
    checkOutput("rev_err_count", 32'(err_count), 32'd0);

    // Jump to 0 is a counter reset; relock downward; 7->3 is an illegal step
    doReset();
    step("rs_6", 6, 7'b0100000);
    step("rs_7", 7, 7'b1100000);
    step("rs_jump0", 0, 7'b0100100);
    step("rs_relock9", 9, 7'b1000000);
    step("rs_8", 8, 7'b1000000);
    step("rs_7b", 7, 7'b1000000);
    step("se_jump3", 3, 7'b0000010);
    checkOutput("se_err_count", 32'(err_count), 32'd1);

    // Out of range while tracking, relock from the retained value, then saturate
    step("rg_lock4", 4, 7'b1100000);
    step("rg_12", 12, 7'b0100001);
    checkOutput("rg_err_count", 32'(err_count), 32'd2);
    step("rg_relock5", 5, 7'b1100000);
    for (int i = 0; i < 252; i++) applyStimulus(1'b1, 12, 1'b0);
    checkOutput("sat_254", 32'(err_count), 32'd254);
    applyStimulus(1'b1, 12, 1'b0);
    checkOutput("sat_255", 32'(err_count), 32'd255);
    checkOutput("sat_flags", 32'(flags), 32'(7'b0100001));
    for (int i = 0; i < 46; i++) applyStimulus(1'b1, 12, 1'b0);
    checkOutput("sat_hold", 32'(err_count), 32'd255);
    applyStimulus(1'b1, 12, 1'b1);
    checkOutput("clr_flags", 32'(flags), 32'(7'b0100001));
    checkOutput("clr_err_count", 32'(err_count), 32'd0);
    applyStimulus(1'b0, 12, 1'b0);
    checkOutput("idle_cycle_flags", 32'(flags), 32'(7'b0100000));
    checkOutput("idle_cycle_err", 32'(err_count), 32'd0);

    // Wrap counting and clear coinciding with a wrap
    step("wc_6", 6, 7'b1100000);
    step("wc_7", 7, 7'b1100000);
    step("wc_8", 8, 7'b1100000);
    step("wc_9", 9, 7'b1100000);
    step("wc_wrap", 0, 7'b1110000);
    checkOutput("wc_count1", 32'(wrap_count), 32'd1);
    for (int v = 1; v < N; v++) applyStimulus(1'b1, v, 1'b0);
    applyStimulus(1'b1, 0, 1'b1);
    checkOutput("wc_clr_flags", 32'(flags), 32'(7'b1110000));
    checkOutput("wc_clr_count", 32'(wrap_count), 32'd0);
    for (int v = 1; v < N; v++) applyStimulus(1'b1, v, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    checkOutput("wc_count_again", 32'(wrap_count), 32'd1);

    // sample_en low leaves state untouched even with a bogus value on the bus
    applyStimulus(1'b0, 5, 1'b0);
    checkOutput("hold_flags", 32'(flags), 32'(7'b1100000));
    step("hold_next", 1, 7'b1100000);

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_flags", 32'(flags), 32'(7'b0100000));
    checkOutput("async_wrap", 32'(wrap_count), 32'd0);
    @(negedge clk);
    sample_en = 1'b0;
    reset     = 1'b1;

    // Out of range in IDLE stays in IDLE, then acquire and relock, reversal across the boundary
    step("idle_range", 15, 7'b0100001);
    checkOutput("idle_range_err", 32'(err_count), 32'd1);
    step("idle_first", 3, 7'b0100000);
    step("acq_lock", 2, 7'b1000000);
    step("bd_1", 1, 7'b1000000);
    step("bd_0", 0, 7'b1000000);
    step("bd_wrap", 9, 7'b1010000);
    step("bd_rev_wrap", 0, 7'b1111000);
    checkOutput("bd_wrap_count", 32'(wrap_count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modn_count_monitor.md
Name: modn_count_monitor

Overview:
- Observes the output bus of a mod-N up/down counter and recovers its direction.
- Checks every sampled step for legality; counts wraps and errors.
- Sits at the consuming end of the counter interface, downstream of the counter; it is the reader of that count stream.
- Used both in-system (health check) and as a bench scoreboard.

Parameters:
N, 10, counter modulus; legal values 0..N-1; N >= 2
W, 4, count bus width; must satisfy 2^W >= N
EW, 8, error counter width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
sample_en  input  1  count_in is sampled on this clk edge
count_in  input  W  counter value under observation
clear_err  input  1  synchronous clear of err_count and wrap_count
dir  output  1  recovered direction: 1 = up, 0 = down
locked  output  1  high while in TRACK
wrap_pulse  output  1  one-cycle pulse on legal wrap (N-1->0 up, 0->N-1 down)
dir_change  output  1  one-cycle pulse on legal direction reversal in TRACK
reset_seen  output  1  one-cycle pulse on non-step jump to 0 (counter reset)
step_err  output  1  one-cycle pulse on illegal step
range_err  output  1  one-cycle pulse when count_in >= N
err_count  output  EW  saturating count of step_err + range_err events
wrap_count  output  16  wrapping count of wrap_pulse events

Behaviour:
- Reset (reset low, asynchronous):
  - State = IDLE, prev = 0, dir = 1.
  - All pulses 0, locked = 0, err_count = 0, wrap_count = 0.
- All outputs are registered. Flags appear one cycle after the sampling edge.
- Pulses last exactly one cycle. No state change when sample_en = 0.
- Arithmetic: up(p) = (p == N-1) ? 0 : p+1; dn(p) = (p == 0) ? N-1 : p-1.
- For N = 2, up(p) == dn(p); the step is classified as a continue in the current dir and never as a reversal.
- States and transitions:
  - IDLE: first sample -> prev = cur, go to ACQ. No flags. If out of range, assert range_err and stay in IDLE.
  - ACQ:
    - cur == up(prev) -> dir = 1, go to TRACK.
    - cur == dn(prev) -> dir = 0, go to TRACK.
    - cur == prev -> stay in ACQ.
    - Otherwise -> step_err, stay in ACQ.
  - TRACK (evaluate in this priority order):
    1. cur >= N -> range_err, go to ACQ, prev unchanged.
    2. Step in current dir -> OK; wrap_pulse if it crossed the N-1/0 boundary.
    3. Step opposite to dir -> dir toggles, dir_change. wrap_pulse also fires if the reversal crossed the boundary.
    4. cur == 0 -> reset_seen, go to ACQ.
    5. cur == prev -> hold, no flag.
    6. Otherwise -> step_err, go to ACQ.
  - In every state, prev = cur on each in-range sample.
  - A range_err sample never updates prev. In ACQ a range_err leaves the state unchanged.
- Counters:
  - err_count increments once per step_err or range_err and saturates at 2^EW-1.
  - wrap_count increments on each wrap_pulse and wraps modulo 2^16.
  - clear_err zeroes both counters. If clear_err coincides with an event, clear wins and the counter ends at 0. Pulses still fire.
- Reset mid-operation: outputs return to reset values immediately, with no clock required. The first sample after reset release is treated as an IDLE sample.
- locked = (state == TRACK), registered.

Test Plan:
- N=10: reset release, then 0,1,...,9,0,1 with sample_en = 1 every cycle -> locked = 1 one cycle after value 1. dir = 1. wrap_pulse exactly once, after 9->0. wrap_count = 1. err_count = 0.
- Down run 5,4,3,2,1,0,9,8 -> dir = 0, locked, one wrap_pulse after 0->9, no errors.
- Reversal 3,4,5,4,3 -> dir_change one cycle after the 5->4 sample. dir goes 1->0. locked stays 1. No step_err.
- Up at 7, then jump to 0 -> reset_seen, locked drops. Next sample 9 -> relock with dir = 0. Jump 7->3 instead -> step_err, err_count = 1, unlock.
- count_in = 12 while in TRACK -> range_err and unlock. err_count increments. prev keeps its last legal value, so a next sample of up(prev) relocks. Then 300 error events -> err_count saturates at 255. clear_err -> 0.
- reset pulsed low between clock edges mid-count -> all outputs go to reset values at once. After release, IDLE then ACQ before locked reasserts.
